alt_vipvfr130_prc_stream_unpacker: RTL and testbench

Next-generation packet reader output engine.
- Accepts per-packet commands (type, sample count) and memory words from the read master's read FIFO.
- Unpacks each word LSB-first into samples of BPS*CHANNELS_IN_PAR bits.
- Emits a VIP Avalon-ST packet: a type header beat, then samples, with sop/eop framing.
- Supports back-to-back packets, discards the unused tail of the last word, and has a selectable ready latency of 0 or 1.

---
 rtl/alt_vipvfr130_prc_pkg.sv | 43 ++++
 rtl/alt_vipvfr130_prc_lane_select.sv | 75 +++++++
 rtl/alt_vipvfr130_prc_stream_unpacker.sv | 191 +++++++++++++++++++
 tb/tb_alt_vipvfr130_prc_stream_unpacker.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipvfr130_prc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alt_vipvfr130_prc_pkg
//  Description : Shared definitions for the packet reader stream unpacker:
//                FSM state encoding, header type constants and constant
//                functions that size the word/lane datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package alt_vipvfr130_prc_pkg;

    // Packet FSM states
    typedef logic [1:0] prc_state_t;
    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_HEADER = 2'd1;
    localparam logic [1:0] STATE_BODY   = 2'd2;

    // Header beat type nibbles
    localparam logic [3:0] HDR_TYPE_VIDEO   = 4'd0;
    localparam logic [3:0] HDR_TYPE_CONTROL = 4'd15;

    // Bits required to index n distinct values (never less than 1)
    function automatic int unsigned prc_req_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < n)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Whole samples held in one memory word; leftover top bits are ignored
    function automatic int unsigned prc_spw(input int unsigned mem_width,
                                            input int unsigned beat_width);
        return mem_width / beat_width;
    endfunction

    // Width of the lane index for a word holding spw samples
    function automatic int unsigned prc_lane_width(input int unsigned spw);
        return prc_req_width(spw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alt_vipvfr130_prc_lane_select.sv
`default_nettype none
// ============================================================================
//  Module      : alt_vipvfr130_prc_lane_select
//  Description : Holds one memory word and presents it LSB-first, one
//                sample lane at a time.
//  Ports       : clock, reset (async active-low)
//                load      - capture word, mark full, lane 0
//                word      - memory word from the read FIFO
//                advance   - current lane consumed
//                flush     - with advance: drop the remaining lanes
//                full      - word register holds unread lanes
//                lane_data - current lane
//                last_lane - current lane is the top whole lane
//  Revision    : 1.0 - initial release
// ============================================================================
module alt_vipvfr130_prc_lane_select
    import alt_vipvfr130_prc_pkg::*;
#(
    parameter int unsigned LANE_WIDTH     = 24,
    parameter int unsigned MEM_PORT_WIDTH = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [MEM_PORT_WIDTH-1:0] word,
    input  logic                      advance,
    input  logic                      flush,
    output logic                      full,
    output logic [LANE_WIDTH-1:0]     lane_data,
    output logic                      last_lane
);

    localparam int unsigned SPW  = prc_spw(MEM_PORT_WIDTH, LANE_WIDTH);
    localparam int unsigned IDXW = prc_lane_width(SPW);
    localparam int unsigned USED = SPW * LANE_WIDTH;

    logic [USED-1:0]       word_reg;
    logic [IDXW-1:0]       lane;
    logic [LANE_WIDTH-1:0] lanes [SPW];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_reg <= '0;
            full     <= 1'b0;
            lane     <= '0;
        end else if (load) begin
            word_reg <= word[USED-1:0];
            full     <= 1'b1;
            lane     <= '0;
        end else if (advance && full) begin
            // Packet end discards whatever lanes are still unread
            if (flush || last_lane) begin
                full <= 1'b0;
                lane <= '0;
            end else begin
                lane <= lane + IDXW'(1);
            end
        end
    end

    for (genvar g = 0; g < SPW; g++) begin : g_lane
        assign lanes[g] = word_reg[g*LANE_WIDTH +: LANE_WIDTH];
    end

    assign lane_data = lanes[lane];
    assign last_lane = (lane == IDXW'(SPW - 1));

    // Bits above the last whole lane never reach the output
    if (MEM_PORT_WIDTH > USED) begin : g_tail
        logic unused_tail;
        assign unused_tail = ^word[MEM_PORT_WIDTH-1:USED];
    end

endmodule
`default_nettype wire

// File: rtl/alt_vipvfr130_prc_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : alt_vipvfr130_prc_stream_unpacker
//  Description : Packet reader output engine. Takes per-packet commands and
//                read-FIFO memory words and emits a VIP Avalon-ST packet:
//                one type header beat followed by the unpacked samples.
//                Optional starvation counter under ALT_VIP_PRC_STARVE_COUNT_EN.
//  Ports       : clock, reset (async active-low)
//                cmd_valid/cmd_ready/cmd_type/cmd_samples - packet command
//                word_valid/word_ready/word_data          - read FIFO
//                dout_*                                   - Avalon-ST source
//                busy        - packet in progress
//                packet_done - pulse the cycle after the eop beat transfers
//                starve_cycles (macro only) - body cycles lost to an empty FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module alt_vipvfr130_prc_stream_unpacker
    import alt_vipvfr130_prc_pkg::*;
#(
    parameter int unsigned BPS             = 8,
    parameter int unsigned CHANNELS_IN_PAR = 3,
    parameter int unsigned MEM_PORT_WIDTH  = 256,
    parameter int unsigned SAMPLES_WIDTH   = 22,
    parameter int unsigned READY_LATENCY   = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [3:0]                        cmd_type,
    input  logic [SAMPLES_WIDTH-1:0]          cmd_samples,
    input  logic                              word_valid,
    output logic                              word_ready,
    input  logic [MEM_PORT_WIDTH-1:0]         word_data,
    input  logic                              dout_ready,
    output logic                              dout_valid,
    output logic [BPS*CHANNELS_IN_PAR-1:0]    dout_data,
    output logic                              dout_startofpacket,
    output logic                              dout_endofpacket,
    output logic                              busy,
    output logic                              packet_done
`ifdef ALT_VIP_PRC_STARVE_COUNT_EN
    ,
    output logic [31:0]                       starve_cycles
`endif
);

    localparam int unsigned DW = BPS * CHANNELS_IN_PAR;

    prc_state_t                state;
    logic [3:0]                pkt_type;
    logic [SAMPLES_WIDTH-1:0]  remaining;
    logic                      alive;
    logic                      accept;
    logic                      avail;
    logic                      take;
    logic                      beat_sop;
    logic                      beat_eop;
    logic [DW-1:0]             beat_data;
    logic                      word_full;
    logic                      word_load;
    logic [DW-1:0]             lane_data;
    logic                      last_lane;

    // Holds cmd_ready low while reset is asserted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    assign cmd_ready  = alive && (state == STATE_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (state != STATE_IDLE);
    assign word_load  = (state == STATE_BODY) && !word_full && word_valid;
    assign word_ready = word_load;

    // Beat offered this cycle, before the output stage
    always_comb begin
        avail     = 1'b0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        beat_data = '0;
        case (state)
            STATE_HEADER: begin
                avail     = 1'b1;
                beat_sop  = 1'b1;
                beat_eop  = (remaining == '0);
                beat_data = DW'(pkt_type);
            end
            STATE_BODY: begin
                if (word_full) begin
                    avail     = 1'b1;
                    beat_eop  = (remaining == SAMPLES_WIDTH'(1));
                    beat_data = lane_data;
                end
            end
            default: ;
        endcase
    end

    // With latency 1 the beat taken now appears on the output next cycle,
    // so both latencies consume a beat on the same internal condition.
    assign take = avail && dout_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= STATE_IDLE;
            pkt_type  <= 4'd0;
            remaining <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (accept) begin
                        pkt_type  <= cmd_type;
                        remaining <= cmd_samples;
                        state     <= STATE_HEADER;
                    end
                end
                STATE_HEADER: begin
                    if (take) state <= (remaining == '0) ? STATE_IDLE : STATE_BODY;
                end
                STATE_BODY: begin
                    if (take) begin
                        remaining <= remaining - SAMPLES_WIDTH'(1);
                        if (beat_eop) state <= STATE_IDLE;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

    alt_vipvfr130_prc_lane_select #(
        .LANE_WIDTH     (DW),
        .MEM_PORT_WIDTH (MEM_PORT_WIDTH)
    ) u_lane_select (
        .clock     (clock),
        .reset     (reset),
        .load      (word_load),
        .word      (word_data),
        .advance   (take && (state == STATE_BODY)),
        .flush     (beat_eop),
        .full      (word_full),
        .lane_data (lane_data),
        .last_lane (last_lane)
    );

    if (READY_LATENCY == 0) begin : g_rl0
        assign dout_valid         = avail;
        assign dout_data          = beat_data;
        assign dout_startofpacket = beat_sop;
        assign dout_endofpacket   = beat_eop;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) packet_done <= 1'b0;
            else        packet_done <= take && beat_eop;
        end
    end else begin : g_rl1
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                dout_valid         <= 1'b0;
                dout_data          <= '0;
                dout_startofpacket <= 1'b0;
                dout_endofpacket   <= 1'b0;
                packet_done        <= 1'b0;
            end else begin
                dout_valid         <= take;
                dout_data          <= take ? beat_data : '0;
                dout_startofpacket <= take && beat_sop;
                dout_endofpacket   <= take && beat_eop;
                // Every registered valid beat is a transfer
                packet_done        <= dout_valid && dout_endofpacket;
            end
        end
    end

`ifdef ALT_VIP_PRC_STARVE_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cycles <= '0;
        end else if (accept) begin
            starve_cycles <= '0;
        end else if ((state == STATE_BODY) && !word_full && !word_valid &&
                     (starve_cycles != 32'hFFFF_FFFF)) begin
            starve_cycles <= starve_cycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alt_vipvfr130_prc_stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alt_vipvfr130_prc_stream_unpacker
//  Description : Self-checking bench. Two instances (ready latency 0 and 1)
//                see the same command/word lists; output beats are compared
//                against a packet-level reference stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alt_vipvfr130_prc_stream_unpacker;

    localparam int BPS  = 8;
    localparam int CH   = 3;
    localparam int MEMW = 256;
    localparam int SW   = 22;
    localparam int DW   = BPS * CH;
    localparam int SPW  = MEMW / DW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shared stimulus and reference stream
    int unsigned     cmd_n[$];
    logic [3:0]      cmd_t[$];
    logic [MEMW-1:0] words[$];
    beat_t           exp_list[$];
    int              ready_pct   = 100;
    int              wv_pct      = 100;
    bit              starve_hold = 1'b0;
    bit              gap_check   = 1'b0;
    bit              ready_pat[$];
    logic            ready_drv   = 1'b0;

    int          eptr_a[2];
    int          widx_a[2];
    int          cidx_a[2];
    logic [7:0]  outs_a[2];
    logic [31:0] starve_a[2];

    initial begin
        forever begin
            @(negedge clock);
            if (ready_pat.size() > 0) ready_drv = ready_pat.pop_front();
            else                      ready_drv = (int'($urandom_range(99)) < ready_pct);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam bit RL1 = (gi == 1);

        logic            cmd_valid;
        logic            cmd_ready;
        logic [3:0]      cmd_type;
        logic [SW-1:0]   cmd_samples;
        logic            word_valid;
        logic            word_ready;
        logic [MEMW-1:0] word_data;
        logic            dout_valid;
        logic [DW-1:0]   dout_data;
        logic            dout_sop;
        logic            dout_eop;
        logic            busy;
        logic            packet_done;
        int              cidx;
        int              widx;
        int              eptr;

        alt_vipvfr130_prc_stream_unpacker #(
            .BPS             (BPS),
            .CHANNELS_IN_PAR (CH),
            .MEM_PORT_WIDTH  (MEMW),
            .SAMPLES_WIDTH   (SW),
            .READY_LATENCY   (gi)
        ) u_dut (
            .clock              (clock),
            .reset              (reset),
            .cmd_valid          (cmd_valid),
            .cmd_ready          (cmd_ready),
            .cmd_type           (cmd_type),
            .cmd_samples        (cmd_samples),
            .word_valid         (word_valid),
            .word_ready         (word_ready),
            .word_data          (word_data),
            .dout_ready         (ready_drv),
            .dout_valid         (dout_valid),
            .dout_data          (dout_data),
            .dout_startofpacket (dout_sop),
            .dout_endofpacket   (dout_eop),
            .busy               (busy),
            .packet_done        (packet_done)
`ifdef ALT_VIP_PRC_STARVE_COUNT_EN
            ,
            .starve_cycles      (starve_a[gi])
`endif
        );

`ifndef ALT_VIP_PRC_STARVE_COUNT_EN
        assign starve_a[gi] = 32'd0;
`endif
        assign outs_a[gi] = {dout_valid, |dout_data, dout_sop, dout_eop,
                             busy, packet_done, cmd_ready, word_ready};
        assign eptr_a[gi] = eptr;
        assign widx_a[gi] = widx;
        assign cidx_a[gi] = cidx;

        // Command and read-FIFO driver
        initial begin
            cmd_valid = 1'b0; cmd_type = 4'd0; cmd_samples = '0;
            word_valid = 1'b0; word_data = '0;
            cidx = 0; widx = 0;
            forever begin
                @(negedge clock);
                if (!reset) begin
                    cidx = 0;
                    widx = 0;
                end
                cmd_valid   = (cidx < cmd_n.size());
                cmd_type    = cmd_valid ? cmd_t[cidx] : 4'd0;
                cmd_samples = cmd_valid ? SW'(cmd_n[cidx]) : '0;
                word_valid  = (widx < words.size()) && !starve_hold &&
                              (int'($urandom_range(99)) < wv_pct);
                word_data   = (widx < words.size()) ? words[widx] : '0;
                #1;
                if (reset && cmd_valid && cmd_ready)   cidx++;
                if (reset && word_valid && word_ready) widx++;
            end
        end

        // Output monitor against the reference stream
        initial begin
            int    cyc;
            int    last_eop_cyc;
            bit    prev_eop_xfer;
            bit    xfer;
            eptr = 0; cyc = 0; last_eop_cyc = -100; prev_eop_xfer = 1'b0;
            forever begin
                @(negedge clock);
                #2;
                cyc++;
                if (!reset) begin
                    eptr          = 0;
                    last_eop_cyc  = -100;
                    prev_eop_xfer = 1'b0;
                end else begin
                    xfer = dout_valid && (RL1 || ready_drv);
                    if (prev_eop_xfer || packet_done)
                        check("packet_done", packet_done, prev_eop_xfer);
                    if (xfer) begin
                        if (eptr < exp_list.size()) begin
                            check("beat_data", dout_data, exp_list[eptr].data);
                            check("beat_sop",  dout_sop,  exp_list[eptr].sop);
                            check("beat_eop",  dout_eop,  exp_list[eptr].eop);
                        end else begin
                            check("extra_beat", eptr, exp_list.size());
                        end
                        if (dout_sop && gap_check && last_eop_cyc >= 0)
                            check("b2b_gap", cyc - last_eop_cyc, 2);
                        if (dout_eop) last_eop_cyc = cyc;
                        eptr++;
                    end
                    prev_eop_xfer = xfer && dout_eop;
                end
            end
        end

        if (RL1) begin : g_rl1_chk
            initial begin
                bit pr;
                pr = 1'b0;
                forever begin
                    @(negedge clock);
                    #2;
                    if (reset && dout_valid) check("rl1_valid_after_ready", pr, 1);
                    pr = reset && ready_drv;
                end
            end
        end else begin : g_rl0_chk
            initial begin
                bit    stalled;
                beat_t held;
                stalled = 1'b0;
                held    = '0;
                forever begin
                    @(negedge clock);
                    #2;
                    if (reset && stalled) begin
                        check("rl0_hold_valid", dout_valid, 1);
                        check("rl0_hold_beat", {dout_data, dout_sop, dout_eop}, held);
                    end
                    stalled = reset && dout_valid && !ready_drv;
                    held    = '{data: dout_data, sop: dout_sop, eop: dout_eop};
                end
            end
        end
    end

    // Reference: header beat then samples taken LSB-first from consecutive
    // words; each packet starts on a fresh word.
    task automatic build_expect();
        int unsigned     wbase;
        int unsigned     nw;
        logic [MEMW-1:0] wd;
        exp_list.delete();
        words.delete();
        wbase = 0;
        foreach (cmd_n[c]) begin
            nw = (cmd_n[c] + SPW - 1) / SPW;
            for (int unsigned w = 0; w < nw; w++) begin
                for (int j = 0; j < MEMW / 32; j++) wd[j*32 +: 32] = $urandom();
                words.push_back(wd);
            end
            exp_list.push_back('{data: DW'(cmd_t[c]), sop: 1'b1, eop: (cmd_n[c] == 0)});
            for (int unsigned k = 0; k < cmd_n[c]; k++) begin
                wd = words[wbase + k / SPW];
                exp_list.push_back('{data: wd[(k % SPW) * DW +: DW], sop: 1'b0,
                                     eop: (k == cmd_n[c] - 1)});
            end
            wbase += nw;
        end
    endtask

    task automatic begin_phase();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #3;
        for (int i = 0; i < 2; i++) check("reset_outputs", outs_a[i], 0);
        build_expect();
        @(negedge clock);
        #4;
        reset = 1'b1;
    endtask

    task automatic wait_phase(input int max_cycles);
        int n;
        n = 0;
        while (n < max_cycles &&
               !(eptr_a[0] == exp_list.size() && eptr_a[1] == exp_list.size())) begin
            @(negedge clock);
            n++;
        end
        check("phase_timeout", n < max_cycles, 1);
        repeat (4) @(negedge clock);
        #3;
        for (int i = 0; i < 2; i++) begin
            check("all_beats", eptr_a[i], exp_list.size());
            check("word_pops", widx_a[i], words.size());
            check("cmds_taken", cidx_a[i], cmd_n.size());
            check("idle_busy", outs_a[i][3], 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: 25 samples over three words, sink always ready
        cmd_n = {25}; cmd_t = {4'd0};
        begin_phase();
        wait_phase(500);
        check("p1_words", widx_a[1], 3);

        // 2: empty packet, control type
        cmd_n = {0}; cmd_t = {4'd15};
        begin_phase();
        wait_phase(200);
        check("p2_words", widx_a[0], 0);

        // 3: back-to-back packets, minimum gap
        cmd_n = {10, 3}; cmd_t = {4'd0, 4'd5};
        gap_check = 1'b1;
        begin_phase();
        wait_phase(500);
        gap_check = 1'b0;

        // 4: toggling ready pattern, FIFO sometimes empty
        cmd_n = {25}; cmd_t = {4'd0};
        wv_pct = 70;
        begin_phase();
        for (int r = 0; r < 30; r++) ready_pat = {ready_pat, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        wait_phase(1000);
        ready_pat.delete();

        // 5: ready held low for five cycles mid-body
        cmd_n = {25}; cmd_t = {4'd0};
        wv_pct = 100;
        begin_phase();
        ready_pat = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        wait_phase(500);

        // Random commands, ready and FIFO availability
        cmd_n.delete(); cmd_t.delete();
        for (int p = 0; p < 8; p++) begin
            cmd_n.push_back($urandom_range(30));
            cmd_t.push_back(4'($urandom_range(15)));
        end
        ready_pct = 60; wv_pct = 70;
        begin_phase();
        wait_phase(5000);
        ready_pct = 100; wv_pct = 100;

        // 6: reset during the body, then a clean packet
        cmd_n = {40}; cmd_t = {4'd0};
        begin_phase();
        n = 0;
        while (n < 500 && eptr_a[0] < 8) begin
            @(negedge clock);
            #2;
            n++;
        end
        check("mid_reset_reach", n < 500, 1);
        #1 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check("async_reset_outputs", outs_a[i], 0);
        cmd_n = {5}; cmd_t = {4'd15};
        begin_phase();
        wait_phase(500);

`ifdef ALT_VIP_PRC_STARVE_COUNT_EN
        // Four body cycles with the FIFO empty
        cmd_n = {5}; cmd_t = {4'd0};
        starve_hold = 1'b1;
        begin_phase();
        n = 0;
        while (n < 100 && cidx_a[0] == 0) begin
            @(negedge clock);
            #2;
            n++;
        end
        check("starve_accept", n < 100, 1);
        repeat (6) @(posedge clock);
        starve_hold = 1'b0;
        wait_phase(500);
        for (int i = 0; i < 2; i++) check("starve_cycles", starve_a[i], 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
